// File: rtl/parallax_step_scheduler.sv
// Per-frame parallax scroll scheduler: fractional phase accumulators issue req/ack steps to layer engines.
// Optional per-layer scroll direction when SCROLL_REVERSE_EN is defined.
module parallax_step_scheduler #(
  parameter int unsigned NUM_LAYERS    = 4,
  parameter int unsigned ACC_W         = 6,
  parameter int unsigned DEFAULT_SPEED = 8,
  localparam int unsigned LW           = $clog2(NUM_LAYERS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_frame_tick,
  input  logic                  i_pause,
  input  logic                  i_cfg_we,
  input  logic [LW-1:0]         i_cfg_layer,
  input  logic [ACC_W:0]        i_cfg_speed,
`ifdef SCROLL_REVERSE_EN
  input  logic                  i_cfg_dir,
  output logic                  o_step_dir,
`endif
  output logic [NUM_LAYERS-1:0] o_step_req,
  input  logic [NUM_LAYERS-1:0] i_step_ack,
  output logic                  o_busy,
  output logic                  o_overrun,
  output logic [7:0]            o_frame_count
);

  localparam logic [ACC_W:0] SPEED_MAX = {1'b1, {ACC_W{1'b0}}};
  localparam logic [ACC_W:0] SPEED_DEF = (ACC_W+1)'(DEFAULT_SPEED);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_WAIT_ACK} state_t;

  state_t                r_state, w_state_nxt;
  logic [LW-1:0]         r_idx, w_idx_nxt;
  logic [ACC_W-1:0]      r_acc   [NUM_LAYERS];
  logic [ACC_W-1:0]      w_acc_nxt [NUM_LAYERS];
  logic [ACC_W:0]        r_speed [NUM_LAYERS];
  logic [ACC_W:0]        w_speed_nxt [NUM_LAYERS];
  logic [NUM_LAYERS-1:0] r_step_req, w_step_req_nxt;
  logic                  r_busy, w_busy_nxt;
  logic                  r_overrun, w_overrun_nxt;
  logic [7:0]            r_frame_count, w_frame_count_nxt;
  logic [ACC_W:0]        w_sum;
  logic [ACC_W:0]        w_cfg_speed;
  logic                  w_last;
  logic                  w_cfg_hit;
`ifdef SCROLL_REVERSE_EN
  logic                  r_dir [NUM_LAYERS];
  logic                  w_dir_nxt [NUM_LAYERS];
  logic                  r_step_dir, w_step_dir_nxt;
`endif

  assign w_sum       = {1'b0, r_acc[r_idx]} + r_speed[r_idx];
  assign w_last      = (r_idx == LW'(NUM_LAYERS - 1));
  assign w_cfg_hit   = i_cfg_we && (32'(i_cfg_layer) < NUM_LAYERS);
  assign w_cfg_speed = (i_cfg_speed > SPEED_MAX) ? SPEED_MAX : i_cfg_speed;

  // Next-state and register-update logic
  always_comb begin
    w_state_nxt       = r_state;
    w_idx_nxt         = r_idx;
    w_acc_nxt         = r_acc;
    w_speed_nxt       = r_speed;
    w_step_req_nxt    = r_step_req;
    w_busy_nxt        = r_busy;
    w_overrun_nxt     = r_overrun;
    w_frame_count_nxt = r_frame_count;
`ifdef SCROLL_REVERSE_EN
    w_dir_nxt         = r_dir;
    w_step_dir_nxt    = r_step_dir;
`endif

    if (w_cfg_hit) begin
      w_speed_nxt[i_cfg_layer] = w_cfg_speed;
`ifdef SCROLL_REVERSE_EN
      w_dir_nxt[i_cfg_layer]   = i_cfg_dir;
`endif
    end

    if (i_frame_tick && (r_state != S_IDLE)) begin
      w_overrun_nxt = 1'b1;
    end

    case (r_state)
      S_IDLE: begin
        if (i_frame_tick && !i_pause) begin
          w_state_nxt = S_SCAN;
          w_idx_nxt   = '0;
          w_busy_nxt  = 1'b1;
        end
      end
      S_SCAN: begin
        w_acc_nxt[r_idx] = w_sum[ACC_W-1:0];
        if (w_sum[ACC_W]) begin
          w_step_req_nxt = NUM_LAYERS'(1) << r_idx;
          w_state_nxt    = S_WAIT_ACK;
`ifdef SCROLL_REVERSE_EN
          w_step_dir_nxt = r_dir[r_idx];
`endif
        end else if (w_last) begin
          w_state_nxt       = S_IDLE;
          w_busy_nxt        = 1'b0;
          w_frame_count_nxt = r_frame_count + 8'd1;
        end else begin
          w_idx_nxt = r_idx + LW'(1);
        end
      end
      S_WAIT_ACK: begin
        if (i_step_ack[r_idx]) begin
          w_step_req_nxt = '0;
          if (w_last) begin
            w_state_nxt       = S_IDLE;
            w_busy_nxt        = 1'b0;
            w_frame_count_nxt = r_frame_count + 8'd1;
          end else begin
            w_state_nxt = S_SCAN;
            w_idx_nxt   = r_idx + LW'(1);
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and datapath registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_idx         <= '0;
      r_step_req    <= '0;
      r_busy        <= 1'b0;
      r_overrun     <= 1'b0;
      r_frame_count <= '0;
      for (int i = 0; i < NUM_LAYERS; i++) begin
        r_acc[i]   <= '0;
        r_speed[i] <= SPEED_DEF;
`ifdef SCROLL_REVERSE_EN
        r_dir[i]   <= 1'b0;
`endif
      end
`ifdef SCROLL_REVERSE_EN
      r_step_dir    <= 1'b0;
`endif
    end else begin
      r_state       <= w_state_nxt;
      r_idx         <= w_idx_nxt;
      r_acc         <= w_acc_nxt;
      r_speed       <= w_speed_nxt;
      r_step_req    <= w_step_req_nxt;
      r_busy        <= w_busy_nxt;
      r_overrun     <= w_overrun_nxt;
      r_frame_count <= w_frame_count_nxt;
`ifdef SCROLL_REVERSE_EN
      r_dir         <= w_dir_nxt;
      r_step_dir    <= w_step_dir_nxt;
`endif
    end
  end

  assign o_step_req    = r_step_req;
  assign o_busy        = r_busy;
  assign o_overrun     = r_overrun;
  assign o_frame_count = r_frame_count;
`ifdef SCROLL_REVERSE_EN
  assign o_step_dir    = r_step_dir;
`endif

endmodule

// File: tb/tb_parallax_step_scheduler.sv
// Self-checking bench for parallax_step_scheduler: table of frame scenarios plus hand-written
// overrun, reset-mid-handshake and (with SCROLL_REVERSE_EN) direction sequences.
module tb_parallax_step_scheduler;

  localparam int NL     = 4;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_frame_tick = 1'b0;
  logic          i_pause = 1'b0;
  logic          i_cfg_we = 1'b0;
  logic [1:0]    i_cfg_layer = '0;
  logic [6:0]    i_cfg_speed = '0;
  logic [NL-1:0] o_step_req;
  logic [NL-1:0] i_step_ack = '0;
  logic          o_busy;
  logic          o_overrun;
  logic [7:0]    o_frame_count;
`ifdef SCROLL_REVERSE_EN
  logic          i_cfg_dir = 1'b0;
  logic          o_step_dir;
`endif

  parallax_step_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_frame_tick (i_frame_tick),
    .i_pause      (i_pause),
    .i_cfg_we     (i_cfg_we),
    .i_cfg_layer  (i_cfg_layer),
    .i_cfg_speed  (i_cfg_speed),
`ifdef SCROLL_REVERSE_EN
    .i_cfg_dir    (i_cfg_dir),
    .o_step_dir   (o_step_dir),
`endif
    .o_step_req   (o_step_req),
    .i_step_ack   (i_step_ack),
    .o_busy       (o_busy),
    .o_overrun    (o_overrun),
    .o_frame_count(o_frame_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state
  int m_acc [NL];
  int m_spd [NL];
  int m_dir [NL];
  int m_fc;
  int m_ovr;
  int q[$];

  typedef struct packed {
    logic [3:0][7:0] spd;
    logic            wr;
    logic [7:0]      frames;
    logic [3:0]      ack_lat;
    logic            pause;
  } vec_t;

  vec_t vecs [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int s0, input int s1, input int s2, input int s3,
                              input bit wr, input int frames, input int ack, input bit pause);
    vec_t v;
    v.spd[0]  = 8'(s0);
    v.spd[1]  = 8'(s1);
    v.spd[2]  = 8'(s2);
    v.spd[3]  = 8'(s3);
    v.wr      = wr;
    v.frames  = 8'(frames);
    v.ack_lat = 4'(ack);
    v.pause   = pause;
    return v;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NL; i++) begin
      m_acc[i] = 0;
      m_spd[i] = 8;
      m_dir[i] = 0;
    end
    m_fc  = 0;
    m_ovr = 0;
    q.delete();
  endfunction

  // Advance the model one frame; returns how many layers step
  function automatic int model_frame();
    int s;
    int n;
    n = 0;
    for (int i = 0; i < NL; i++) begin
      s = m_acc[i] + m_spd[i];
      m_acc[i] = s % 64;
      if (s >= 64) begin
        q.push_back(i);
        n++;
      end
    end
    m_fc = (m_fc + 1) % 256;
    return n;
  endfunction

  task automatic cfg_write(input int layer, input int spd, input bit dir);
    i_cfg_we    = 1'b1;
    i_cfg_layer = 2'(layer);
    i_cfg_speed = 7'(spd);
`ifdef SCROLL_REVERSE_EN
    i_cfg_dir   = dir;
`endif
    @(negedge clk);
    i_cfg_we = 1'b0;
    m_spd[layer] = (spd > 64) ? 64 : spd;
    m_dir[layer] = dir;
  endtask

  task automatic run_frame(input int ack_lat);
    int n_exp;
    int e;
    int cyc;
    int busy_cyc;
    logic [NL-1:0] oh;
    n_exp = model_frame();
    i_frame_tick = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0;
    check("busy_rise", o_busy, 1);
    cyc = 0;
    busy_cyc = 0;
    while (o_busy && cyc < BUDGET) begin
      cyc++;
      if (o_step_req != '0) begin
        if (q.size() == 0) begin
          check("unexpected_req", o_step_req, 0);
          i_step_ack = o_step_req;
          @(negedge clk);
          i_step_ack = '0;
        end else begin
          e  = q.pop_front();
          oh = NL'(1) << e;
          check("step_req", o_step_req, oh);
`ifdef SCROLL_REVERSE_EN
          check("step_dir", o_step_dir, m_dir[e]);
`endif
          for (int k = 1; k < ack_lat; k++) begin
            i_step_ack = 4'($urandom) & ~oh;
            @(negedge clk);
            check("req_hold", o_step_req, oh);
`ifdef SCROLL_REVERSE_EN
            check("step_dir_hold", o_step_dir, m_dir[e]);
`endif
          end
          i_step_ack = oh;
          @(negedge clk);
          i_step_ack = '0;
          check("req_drop", o_step_req, 0);
        end
      end else begin
        busy_cyc++;
        @(negedge clk);
      end
    end
    check("frame_done", (cyc < BUDGET), 1);
    check("missing_req", q.size(), 0);
    q.delete();
    if (n_exp == 0) check("busy_cycles", busy_cyc, NL);
    check("frame_count", o_frame_count, m_fc);
    check("overrun", o_overrun, m_ovr);
  endtask

  task automatic paused_tick();
    i_pause      = 1'b1;
    i_frame_tick = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0;
    check("pause_busy", o_busy, 0);
    repeat (3) @(negedge clk);
    check("pause_req", o_step_req, 0);
    check("pause_fc", o_frame_count, m_fc);
    i_pause = 1'b0;
  endtask

  task automatic wait_req(input string name, input logic [NL-1:0] exp);
    int cyc;
    cyc = 0;
    while (o_step_req == '0 && cyc < 10) begin
      @(negedge clk);
      cyc++;
    end
    check(name, o_step_req, exp);
  endtask

  initial begin
    vecs[0] = mk(8, 8, 8, 8, 1'b0, 8, 1, 1'b0);
    vecs[1] = mk(0, 0, 64, 0, 1'b1, 2, 3, 1'b0);
    vecs[2] = mk(0, 100, 0, 0, 1'b1, 2, 1, 1'b0);
    vecs[3] = mk(0, 0, 0, 0, 1'b0, 3, 1, 1'b1);
    vecs[4] = mk(127, 33, 17, 5, 1'b1, 6, 2, 1'b0);
    vecs[5] = mk(64, 64, 64, 64, 1'b1, 2, 2, 1'b0);

    model_reset();
    repeat (3) @(negedge clk);
    check("rst_req", o_step_req, 0);
    check("rst_busy", o_busy, 0);
    check("rst_overrun", o_overrun, 0);
    check("rst_fc", o_frame_count, 0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      if (vecs[v].wr) begin
        for (int l = 0; l < NL; l++) cfg_write(l, int'(vecs[v].spd[l]), 1'b0);
      end
      for (int f = 0; f < int'(vecs[v].frames); f++) begin
        if (vecs[v].pause) paused_tick();
        else run_frame(int'(vecs[v].ack_lat));
      end
    end

    // Overrun: tick arrives while layer 0 is held in its handshake
    cfg_write(0, 64, 1'b0);
    for (int l = 1; l < NL; l++) cfg_write(l, 0, 1'b0);
    void'(model_frame());
    q.delete();
    i_frame_tick = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0;
    wait_req("ovr_req", 4'b0001);
    repeat (25) @(negedge clk);
    i_frame_tick = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0;
    repeat (24) @(negedge clk);
    m_ovr = 1;
    check("ovr_flag", o_overrun, 1);
    check("ovr_req_held", o_step_req, 4'b0001);
    check("ovr_busy", o_busy, 1);
    i_step_ack = 4'b0001;
    @(negedge clk);
    i_step_ack = '0;
    check("ovr_req_drop", o_step_req, 0);
    repeat (5) @(negedge clk);
    check("ovr_busy_end", o_busy, 0);
    check("ovr_fc", o_frame_count, m_fc);
    run_frame(1);

    // Reset while waiting for an ack
    void'(model_frame());
    i_frame_tick = 1'b1;
    @(negedge clk);
    i_frame_tick = 1'b0;
    wait_req("rst_mid_req", 4'b0001);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid_req_drop", o_step_req, 0);
    check("rst_mid_busy", o_busy, 0);
    check("rst_mid_fc", o_frame_count, 0);
    check("rst_mid_overrun", o_overrun, 0);
    rst_n = 1'b1;
    model_reset();
    @(negedge clk);
    for (int f = 0; f < 8; f++) run_frame(1);

`ifdef SCROLL_REVERSE_EN
    for (int l = 0; l < NL - 1; l++) cfg_write(l, 0, 1'b0);
    cfg_write(3, 64, 1'b1);
    run_frame(3);
    cfg_write(3, 64, 1'b0);
    run_frame(2);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
